// File: rtl/melody_sequencer.sv
// melody_sequencer: walks a score ROM of 16-bit event words and drives the
// synthesizer's start/stop/note inputs, timing each event in prescaled ticks.
module melody_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int TICK_DIV  = 12000,
  parameter int GAP_TICKS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play,
  input  logic              halt,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              start,
  output logic              stop,
  output logic [6:0]        note,
  output logic              busy,
  output logic              done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DECODE,
    HOLD
  } state_e;

  state_e            stateQ;
  logic [ADDR_W-1:0] pcQ;
  logic [PW-1:0]     prescQ;
  logic [6:0]        ticksQ;
  logic              isNoteQ;
  logic              startQ;
  logic              stopQ;
  logic              doneQ;
  logic              busyQ;
  logic [6:0]        noteQ;

  logic [1:0]        opD;
  logic [6:0]        durD;
  logic [ADDR_W-1:0] pcNextD;
  logic              gapHitD;

  // Decode the current score word and flag the cycle just before the articulation gap starts.
  always_comb begin
    opD     = rom_data[15:14];
    durD    = (rom_data[6:0] == 7'd0) ? 7'd1 : rom_data[6:0];
    pcNextD = pcQ + ADDR_W'(1);
    gapHitD = (GAP_TICKS > 0) && isNoteQ && (prescQ == PRESC_LAST) &&
              (32'(ticksQ) == GAP_TICKS + 1);
  end

  // Playback FSM: halt overrides everything; every output is a register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ  <= IDLE;
      pcQ     <= '0;
      prescQ  <= '0;
      ticksQ  <= '0;
      isNoteQ <= 1'b0;
      startQ  <= 1'b0;
      stopQ   <= 1'b0;
      doneQ   <= 1'b0;
      busyQ   <= 1'b0;
      noteQ   <= '0;
    end else begin
      startQ <= 1'b0;
      stopQ  <= 1'b0;
      doneQ  <= 1'b0;
      if (halt && stateQ != IDLE) begin
        stateQ <= IDLE;
        busyQ  <= 1'b0;
        pcQ    <= '0;
        stopQ  <= 1'b1;
        prescQ <= '0;
        ticksQ <= '0;
      end else begin
        case (stateQ)
          IDLE: begin
            if (play && !halt) begin
              stateQ <= FETCH;
              busyQ  <= 1'b1;
              pcQ    <= '0;
            end
          end
          FETCH: begin
            stateQ <= DECODE;
          end
          DECODE: begin
            prescQ <= '0;
            ticksQ <= durD;
            case (opD)
              2'b00: begin
                noteQ   <= rom_data[13:7];
                startQ  <= 1'b1;
                isNoteQ <= 1'b1;
                pcQ     <= pcNextD;
                stateQ  <= HOLD;
              end
              2'b01: begin
                stopQ   <= 1'b1;
                isNoteQ <= 1'b0;
                pcQ     <= pcNextD;
                stateQ  <= HOLD;
              end
              2'b10: begin
                if (loop) begin
                  pcQ    <= rom_data[ADDR_W-1:0];
                  stateQ <= FETCH;
                end else begin
                  stopQ  <= 1'b1;
                  doneQ  <= 1'b1;
                  busyQ  <= 1'b0;
                  pcQ    <= '0;
                  stateQ <= IDLE;
                end
              end
              default: begin
                stopQ  <= 1'b1;
                doneQ  <= 1'b1;
                busyQ  <= 1'b0;
                pcQ    <= '0;
                stateQ <= IDLE;
              end
            endcase
          end
          HOLD: begin
            if (gapHitD) begin
              stopQ <= 1'b1;
            end
            if (prescQ == PRESC_LAST) begin
              prescQ <= '0;
              ticksQ <= ticksQ - 7'd1;
              if (ticksQ == 7'd1) begin
                stateQ <= FETCH;
              end
            end else begin
              prescQ <= prescQ + PW'(1);
            end
          end
          default: begin
            stateQ <= IDLE;
            busyQ  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rom_addr = pcQ;
  assign start    = startQ;
  assign stop     = stopQ;
  assign done     = doneQ;
  assign busy     = busyQ;
  assign note     = noteQ;

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: directed and random score programs compared cycle by
// cycle against an event-timeline model of the sequencer.
module tb_melody_sequencer;

  localparam int AW    = 5;
  localparam int TD    = 4;
  localparam int GT    = 1;
  localparam int DEPTH = 32;
  localparam int MAXC  = 600;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          play = 1'b0;
  logic          halt = 1'b0;
  logic          loopLvl = 1'b0;
  logic [AW-1:0] romAddr;
  logic [15:0]   romData;
  logic          start;
  logic          stop;
  logic          done;
  logic          busy;
  logic [6:0]    note;

  logic [15:0]   rom [DEPTH];

  int total = 0;
  int bad = 0;

  bit expStart [MAXC];
  bit expStop  [MAXC];
  bit expDone  [MAXC];
  bit expBusy  [MAXC];
  int expNote  [MAXC];
  int expAddr  [MAXC];
  int modelNote = 0;
  int lastCycle = 0;

  melody_sequencer #(
    .ADDR_W   (AW),
    .TICK_DIV (TD),
    .GAP_TICKS(GT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .play    (play),
    .halt    (halt),
    .loop    (loopLvl),
    .rom_addr(romAddr),
    .rom_data(romData),
    .start   (start),
    .stop    (stop),
    .note    (note),
    .busy    (busy),
    .done    (done)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Synchronous score ROM: data for an address appears one cycle later
  always @(posedge clk) romData <= rom[romAddr];

  function automatic logic [15:0] mkWord(input int op, input int n, input int d);
    logic [15:0] w;
    w = {op[1:0], n[6:0], d[6:0]};
    return w;
  endfunction

  function automatic logic [15:0] mkJump(input int target);
    logic [15:0] w;
    w = {2'b10, target[13:0]};
    return w;
  endfunction

  task automatic clearRom();
    for (int i = 0; i < DEPTH; i++) rom[i] = 16'hC000;
  endtask

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Build the expected per-cycle timeline from the score: event times follow
  // FETCH -> DECODE -> pulse, holds last D*TD cycles, jumps cost two cycles.
  task automatic buildModel(input bit loopV, input int haltAt);
    int c, addr, d, ev, op, w, hc;
    bit running;
    for (int i = 0; i < MAXC; i++) begin
      expStart[i] = 0; expStop[i] = 0; expDone[i] = 0; expBusy[i] = 0;
      expNote[i] = modelNote; expAddr[i] = 0;
    end
    lastCycle = 2;
    if (haltAt == 0) return;
    c = 1; addr = 0; running = 1; lastCycle = MAXC - 4;
    while (running && c + 2 < MAXC) begin
      w  = int'(rom[addr]);
      op = w[15:14];
      d  = (w[6:0] == 0) ? 1 : w[6:0];
      ev = c + 2;
      expBusy[c] = 1; expBusy[c+1] = 1;
      expAddr[c] = addr; expAddr[c+1] = addr;
      if (op == 0 || op == 1) begin
        if (op == 0) begin
          expStart[ev] = 1;
          for (int j = ev; j < MAXC; j++) expNote[j] = w[13:7];
          if (GT > 0 && d > GT) begin
            hc = ev + (d - GT) * TD;
            if (hc < MAXC) expStop[hc] = 1;
          end
        end else begin
          expStop[ev] = 1;
        end
        for (int j = ev; j < ev + d * TD && j < MAXC; j++) begin
          expBusy[j] = 1;
          expAddr[j] = (addr + 1) % DEPTH;
        end
        addr = (addr + 1) % DEPTH;
        c = ev + d * TD;
      end else if (op == 2 && loopV) begin
        addr = w & (DEPTH - 1);
        c = c + 2;
      end else begin
        expStop[ev] = 1;
        expDone[ev] = 1;
        lastCycle = ev;
        running = 0;
      end
    end
    if (haltAt > 0 && haltAt < MAXC - 4 && expBusy[haltAt]) begin
      for (int j = haltAt + 1; j < MAXC; j++) begin
        expStart[j] = 0; expStop[j] = 0; expDone[j] = 0; expBusy[j] = 0;
        expAddr[j] = 0; expNote[j] = expNote[haltAt];
      end
      expStop[haltAt+1] = 1;
      lastCycle = haltAt + 1;
    end
  endtask

  task automatic checkOutput(input string tag, input int n);
    chk({tag, ".start"}, n, 32'(start), 32'(expStart[n]));
    chk({tag, ".stop"},  n, 32'(stop),  32'(expStop[n]));
    chk({tag, ".done"},  n, 32'(done),  32'(expDone[n]));
    chk({tag, ".busy"},  n, 32'(busy),  32'(expBusy[n]));
    chk({tag, ".note"},  n, 32'(note),  32'(expNote[n]));
    chk({tag, ".addr"},  n, 32'(romAddr), 32'(expAddr[n]));
  endtask

  task automatic applyStimulus(input string tag, input bit loopV, input int haltAt,
                               input int playAgainAt);
    int lim;
    buildModel(loopV, haltAt);
    loopLvl = loopV;
    lim = lastCycle + 3;
    if (lim > MAXC - 1) lim = MAXC - 1;
    for (int n = 0; n <= lim; n++) begin
      @(posedge clk);
      #1;
      play = (n == 0) || (n == playAgainAt);
      halt = (n == haltAt);
      checkOutput(tag, n);
    end
    play = 0;
    halt = 0;
    modelNote = expNote[lim];
  endtask

  initial begin
    int op, hAt;
    bit lv;
    clearRom();
    $display("[TB] reset with play held high");
    rst_n = 0;
    play = 1;
    buildModel(0, 0);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      checkOutput("reset", n);
    end
    rst_n = 1;
    play = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #1;
      checkOutput("postReset", n);
    end

    $display("[TB] note then end, with ignored replay");
    rom[0] = mkWord(0, 'h25, 3);
    rom[1] = mkWord(3, 0, 0);
    applyStimulus("noteEnd", 0, -1, 6);

    $display("[TB] halt inside a note hold");
    applyStimulus("haltHold", 0, 8, -1);

    $display("[TB] halt and play together while idle");
    applyStimulus("haltPlay", 0, 0, -1);

    $display("[TB] note, rest, jump");
    clearRom();
    rom[0] = mkWord(0, 'h10, 2);
    rom[1] = mkWord(1, 0, 2);
    rom[2] = mkJump(0);
    applyStimulus("jumpNoLoop", 0, -1, -1);
    applyStimulus("jumpLoop", 1, 45, -1);

    $display("[TB] zero and one tick durations");
    clearRom();
    rom[0] = mkWord(0, 'h33, 0);
    rom[1] = mkWord(0, 'h44, 1);
    rom[2] = mkWord(1, 0, 0);
    rom[3] = mkWord(3, 0, 0);
    applyStimulus("shortDur", 0, -1, -1);

    $display("[TB] program counter wrap");
    clearRom();
    rom[0]  = mkJump(30);
    rom[30] = mkWord(0, 'h7F, 1);
    rom[31] = mkWord(0, 'h01, 2);
    applyStimulus("wrap", 1, 60, -1);
    applyStimulus("jumpStop", 0, -1, -1);

    $display("[TB] random score programs");
    for (int it = 0; it < 12; it++) begin
      clearRom();
      for (int a = 0; a < 8; a++) begin
        op = $urandom_range(0, 7);
        if (op < 3)      rom[a] = mkWord(0, $urandom_range(0, 127), $urandom_range(0, 5));
        else if (op < 6) rom[a] = mkWord(1, $urandom_range(0, 127), $urandom_range(0, 5));
        else if (op == 6) rom[a] = mkJump($urandom_range(0, 7));
        else             rom[a] = mkWord(3, 0, 0);
      end
      lv = 1'($urandom_range(0, 1));
      if (lv) hAt = $urandom_range(3, 200);
      else hAt = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 80) : -1;
      applyStimulus("random", lv, hAt, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
